// File: rtl/hier_deser_rx_if.sv
// Receive-side handshake bundle: received word, valid/ready and status flags.
interface hier_deser_rx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    output data_out,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/hier_deser_rx.sv
// Inverted-polarity serial receiver built as three nested levels:
// bit synchronizer leaf, shift-register level, FSM/handshake top.

// Two-flop synchronizer; output is re-inverted so idle (line low) reads as 1.
module hier_deser_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic rx
);
  logic [1:0] sync_q;

  // Shift the raw line through two flops.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], line_in};
  end

  assign rx = ~sync_q[1];
endmodule

// Data shift register: writes the sampled bit at the current bit index.
module hier_deser_rx_shreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [IW-1:0]    idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shreg
);
  logic [WIDTH-1:0] shreg_q;

  // Capture one data bit per sample strobe, LSB first.
  always_ff @(posedge clk) begin
    if (reset)         shreg_q      <= '0;
    else if (shift_en) shreg_q[idx] <= bit_in;
  end

  assign shreg = shreg_q;
endmodule

// Frame FSM and valid/ready output stage.
module hier_deser_rx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            line_in,
  hier_deser_rx_if.master rx_if
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx;
  logic             shift_en;
  logic [WIDTH-1:0] shreg;

  hier_deser_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (line_in),
    .rx      (rx)
  );

  hier_deser_rx_shreg #(.WIDTH(WIDTH), .IW(IW)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .idx      (idx_q),
    .bit_in   (rx),
    .shreg    (shreg)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, sample strobes and handshake update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q && !rx_if.ready;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx) begin
            // An accept in this same cycle frees the slot for the new word.
            if (!valid_q || rx_if.ready) begin
              data_d  = shreg;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.data_out  = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;
endmodule

// File: tb/tb_hier_deser_rx.sv
// Scoreboard bench for hier_deser_rx: directed scenarios plus random frames.
module tb_hier_deser_rx;
  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;
  localparam int LAT = 2 + CPB/2 + (W+1)*CPB + 1;

  logic clk = 1'b0;
  logic reset;
  logic line_in;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hier_deser_rx_if #(.WIDTH(W)) bus ();

  hier_deser_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .line_in (line_in),
    .rx_if   (bus.master)
  );

  typedef struct {
    bit           is_ferr;
    logic [W-1:0] data;
    int           t;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_pending = 1'b0;
  bit   m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake or frame error pops one expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid && bus.ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_word: got %0h expected no word (cycle %0d)", bus.data_out, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("event_kind_word", 32'(0), 32'(e.is_ferr));
          check("word_data", 32'(bus.data_out), 32'(e.data));
          if (e.t >= 0) check("word_latency", cyc, e.t);
        end
      end
      if (bus.frame_err) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_frame_err: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("event_kind_ferr", 32'(1), 32'(e.is_ferr));
          if (e.t >= 0) check("ferr_latency", cyc, e.t);
        end
      end
    end
  end

  // Drives one frame; the model decides the outcome from the frame-level rules.
  // rac: the consumer is ready in the completion cycle.
  task automatic send_frame(input logic [W-1:0] d, input bit good, input bit rac, input bit abandon);
    int c;
    exp_t e;
    c = cyc;
    if (!abandon) begin
      if (!good) begin
        e.is_ferr = 1'b1; e.data = '0; e.t = c + LAT;
        sbq.push_back(e);
      end else if (!m_pending || rac) begin
        e.is_ferr = 1'b0; e.data = d; e.t = rac ? c + LAT : -1;
        sbq.push_back(e);
        m_pending = !rac;
      end else begin
        m_ovr = 1'b1;
      end
    end
    line_in = 1'b1;
    wait_cycles(CPB);
    for (int i = 0; i < int'(W); i++) begin
      line_in = ~d[i];
      wait_cycles(CPB);
    end
    line_in = good ? 1'b0 : 1'b1;
    wait_cycles(CPB);
    line_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_ferr", 32'(bus.frame_err), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_pending = 1'b0;
    m_ovr = 1'b0;
    sbq.delete();
    wait_cycles(2);
  endtask

  initial begin
    reset = 1'b1;
    line_in = 1'b0;
    bus.ready = 1'b1;
    wait_cycles(1);
    do_reset();

    // 1: basic frame, latency and one-cycle valid
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_valid_not_early", 32'(bus.valid), 0);
    @(negedge clk);
    check("t1_valid", 32'(bus.valid), 1);
    check("t1_data", 32'(bus.data_out), 32'hA5);
    check("t1_ovr", 32'(bus.overrun), 0);
    @(negedge clk);
    check("t1_valid_dropped", 32'(bus.valid), 0);
    @(posedge clk); #1;

    // 2: one-cycle glitch aborts in START
    line_in = 1'b1;
    wait_cycles(1);
    line_in = 1'b0;
    wait_cycles(100);
    check("t2_no_valid", 32'(bus.valid), 0);

    // 3: bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_cycles(3);
    check("t3_data_kept", 32'(bus.data_out), 32'hA5);
    check("t3_valid", 32'(bus.valid), 0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    wait_cycles(4);
    check("t3_next_data", 32'(bus.data_out), 32'h01);

    // 4: stalled consumer, back-to-back frames cause overrun
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    wait_cycles(2);
    check("t4_valid", 32'(bus.valid), 1);
    check("t4_data", 32'(bus.data_out), 32'h11);
    check("t4_ovr", 32'(bus.overrun), 32'(m_ovr));
    bus.ready = 1'b1;
    m_pending = 1'b0;
    wait_cycles(3);
    check("t4_valid_dropped", 32'(bus.valid), 0);
    check("t4_data_kept", 32'(bus.data_out), 32'h11);

    // 5: accept and completion in the same cycle
    do_reset();
    bus.ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h66, 1'b1, 1'b1, 1'b0);
      begin
        wait_cycles(40);
        bus.ready = 1'b1;
      end
    join
    wait_cycles(1);
    check("t5_valid", 32'(bus.valid), 1);
    check("t5_data", 32'(bus.data_out), 32'h66);
    check("t5_ovr", 32'(bus.overrun), 0);
    wait_cycles(2);

    // 6: reset mid-DATA abandons the frame
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
      begin
        wait_cycles(22);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        m_pending = 1'b0;
        m_ovr = 1'b0;
        check("t6_rst_data", 32'(bus.data_out), 0);
        check("t6_rst_valid", 32'(bus.valid), 0);
        check("t6_rst_ferr", 32'(bus.frame_err), 0);
      end
    join
    wait_cycles(4);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    wait_cycles(4);
    check("t6_next_data", 32'(bus.data_out), 32'h81);

    // Random frames, mostly good, back-to-back or with short gaps and glitches
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] d;
      bit good;
      int gap;
      d = W'($urandom);
      good = ($urandom_range(0, 9) != 0);
      send_frame(d, good, 1'b1, 1'b0);
      gap = good ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
      if (gap > 0) wait_cycles(gap);
      if ($urandom_range(0, 4) == 0) begin
        line_in = 1'b1;
        wait_cycles(1);
        line_in = 1'b0;
        wait_cycles(8);
      end
    end

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    check("final_ovr", 32'(bus.overrun), 32'(m_ovr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
